// File: rtl/input_buffer_loader.sv
// input_buffer_loader: fills the input activation buffer from input SRAM, one
// SRAM line per buffer write, then presents the finished tile to the PE array
// until the consumer releases it.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for start; base address captured on start
//   S_REQ   | one-cycle SRAM read request for the current chunk
//   S_WAIT  | request outstanding; latch line data when the SRAM answers
//   S_WRITE | buffer write strobe with registered data/row/column
//   S_READY | tile complete; buffer read enabled until release
module input_buffer_loader #(
  parameter int BIN_LEN        = 16,
  parameter int INPUT_HEIGHT   = 4,
  parameter int INPUT_WIDTH    = 8,
  parameter int INPUT_SRAM_LEN = 4,
  parameter int ADDR_LEN       = 12,
  localparam int ROW_W  = (INPUT_HEIGHT > 1) ? $clog2(INPUT_HEIGHT) : 1,
  localparam int COL_W  = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1,
  localparam int LINE_W = BIN_LEN * INPUT_SRAM_LEN
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [ADDR_LEN-1:0] base_addr_i,
  input  logic                release_i,
  output logic                busy_o,
  output logic                tile_ready_o,
  output logic                done_o,
  output logic                sram_rd_req_o,
  output logic [ADDR_LEN-1:0] sram_rd_addr_o,
  input  logic                sram_rd_valid_i,
  input  logic [LINE_W-1:0]   sram_rd_data_i,
  output logic                buf_w_enable_o,
  output logic [LINE_W-1:0]   buf_in_o,
  output logic [ROW_W-1:0]    buf_r_o,
  output logic [COL_W-1:0]    buf_c_o,
  output logic                buf_r_enable_o
);

  localparam int CPR   = INPUT_WIDTH / INPUT_SRAM_LEN;
  localparam int CHK_W = (CPR > 1) ? $clog2(CPR) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(INPUT_HEIGHT - 1);
  localparam logic [CHK_W-1:0] LAST_CHUNK = CHK_W'(CPR - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_READY = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [CHK_W-1:0]    chunk_q, chunk_d;
  // Tiles are fetched in row-major order, so the line address is simply
  // base + linear chunk index; a running pointer avoids the row*CPR multiply
  // and wraps modulo 2^ADDR_LEN by construction.
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [ROW_W-1:0]    buf_r_q, buf_r_d;
  logic [COL_W-1:0]    buf_c_q, buf_c_d;
  logic                done_q, done_d;
  logic                last_chunk;

  assign last_chunk = (row_q == LAST_ROW) && (chunk_q == LAST_CHUNK);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      chunk_q <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      buf_r_q <= '0;
      buf_c_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      chunk_q <= chunk_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      buf_r_q <= buf_r_d;
      buf_c_q <= buf_c_d;
      done_q  <= done_d;
    end
  end

  // Next-state and counter/datapath update logic.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    chunk_d = chunk_q;
    addr_d  = addr_q;
    line_d  = line_q;
    buf_r_d = buf_r_q;
    buf_c_d = buf_c_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_REQ;
          addr_d  = base_addr_i;
          row_d   = '0;
          chunk_d = '0;
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (sram_rd_valid_i) begin
          state_d = S_WRITE;
          line_d  = sram_rd_data_i;
          buf_r_d = row_q;
          buf_c_d = COL_W'(32'(chunk_q) * INPUT_SRAM_LEN);
        end
      end
      S_WRITE: begin
        if (last_chunk) begin
          state_d = S_READY;
          done_d  = 1'b1;
        end else begin
          state_d = S_REQ;
          addr_d  = addr_q + ADDR_LEN'(1);
          if (chunk_q == LAST_CHUNK) begin
            chunk_d = '0;
            row_d   = row_q + ROW_W'(1);
          end else begin
            chunk_d = chunk_q + CHK_W'(1);
          end
        end
      end
      S_READY: begin
        if (release_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o         = (state_q != S_IDLE);
  assign tile_ready_o   = (state_q == S_READY);
  assign buf_r_enable_o = (state_q == S_READY);
  assign done_o         = done_q;
  assign sram_rd_req_o  = (state_q == S_REQ);
  assign sram_rd_addr_o = addr_q;
  assign buf_w_enable_o = (state_q == S_WRITE);
  assign buf_in_o       = line_q;
  assign buf_r_o        = buf_r_q;
  assign buf_c_o        = buf_c_q;

endmodule

// File: tb/tb_input_buffer_loader.sv
// Testbench for input_buffer_loader: random-latency SRAM responder, a
// schedule-based reference model of the tile fill, a per-cycle compare
// process, and literal expectations for the directed scenarios.
module tb_input_buffer_loader;

  localparam int BL  = 16;
  localparam int H   = 4;
  localparam int W   = 8;
  localparam int SL  = 4;
  localparam int AL  = 12;
  localparam int CPR = W / SL;
  localparam int NCH = H * CPR;
  localparam int LW  = BL * SL;

  logic          clk = 1'b0;
  logic          reset, start, release_s;
  logic [AL-1:0] base_addr;
  logic          busy, tile_ready, done, rd_req, rd_valid, wen, r_en;
  logic [AL-1:0] rd_addr;
  logic [LW-1:0] rd_data, buf_in;
  logic [1:0]    buf_r;
  logic [2:0]    buf_c;

  always #5 clk = ~clk;

  input_buffer_loader #(
    .BIN_LEN(BL), .INPUT_HEIGHT(H), .INPUT_WIDTH(W),
    .INPUT_SRAM_LEN(SL), .ADDR_LEN(AL)
  ) dut (
    .clock_i(clk), .reset_i(reset), .start_i(start), .base_addr_i(base_addr),
    .release_i(release_s), .busy_o(busy), .tile_ready_o(tile_ready),
    .done_o(done), .sram_rd_req_o(rd_req), .sram_rd_addr_o(rd_addr),
    .sram_rd_valid_i(rd_valid), .sram_rd_data_i(rd_data),
    .buf_w_enable_o(wen), .buf_in_o(buf_in), .buf_r_o(buf_r),
    .buf_c_o(buf_c), .buf_r_enable_o(r_en)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a tile is NCH chunks fetched in linear order; each chunk
  // is request -> first accepted valid -> write one cycle later, and the next
  // request follows the write. Times are cycle labels (cycle after edge N).
  int            cyc      = 0;
  int            phase    = 0;   // 0 idle, 1 filling, 2 ready
  logic [AL-1:0] m_base   = '0;
  int            m_idx    = 0;
  bit            m_wait   = 0;
  int            req_due  = -1;
  int            wr_due   = -1;
  int            done_due = -1;
  logic [LW-1:0] m_line   = '0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      phase = 0; m_wait = 0; req_due = -1; wr_due = -1; done_due = -1; m_line = '0;
    end else begin
      case (phase)
        0: if (start) begin
          m_base = base_addr; m_idx = 0; phase = 1; req_due = cyc;
        end
        1: begin
          if (cyc - 1 == req_due) m_wait = 1;
          else if (m_wait && rd_valid) begin
            m_line = rd_data; m_wait = 0; wr_due = cyc;
          end else if (cyc - 1 == wr_due) begin
            if (m_idx == NCH - 1) begin phase = 2; done_due = cyc; end
            else begin m_idx++; req_due = cyc; end
          end
        end
        default: if (release_s) phase = 0;
      endcase
    end
  end

  int req_log[$];
  int wr_log[$];
  int done_log[$];

  // Per-cycle compare against the model, plus event logs for literal checks.
  always @(negedge clk) begin
    bit er, ew;
    if (cyc > 0) begin
      er = (cyc == req_due);
      ew = (cyc == wr_due);
      chk("busy", busy, phase != 0);
      chk("tile_ready", tile_ready, phase == 2);
      chk("buf_r_enable", r_en, phase == 2);
      chk("done", done, cyc == done_due);
      chk("sram_rd_req", rd_req, er);
      chk("buf_w_enable", wen, ew);
      chk("buf_in", buf_in, m_line);
      if (er) chk("sram_rd_addr", rd_addr, AL'(m_base + AL'(m_idx)));
      if (ew) begin
        chk("buf_r", buf_r, m_idx / CPR);
        chk("buf_c", buf_c, (m_idx % CPR) * SL);
      end
      if (rd_req) req_log.push_back(int'(rd_addr));
      if (wen) wr_log.push_back(int'(buf_r) * 100 + int'(buf_c));
      if (done) done_log.push_back(cyc);
    end
  end

  // SRAM responder: fixed or random latency, optional spurious valids while
  // no request is outstanding.
  int lat_fix  = 1;
  bit lat_rand = 0;
  bit spur_en  = 0;

  initial begin : responder
    bit pend;
    int cnt;
    pend = 0; cnt = 0;
    rd_valid = 1'b0; rd_data = '0;
    forever begin
      @(posedge clk); #2;
      rd_valid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          rd_valid = 1'b1; rd_data = {$urandom, $urandom}; pend = 0;
        end
      end else if (spur_en && $urandom_range(0, 2) == 0) begin
        rd_valid = 1'b1; rd_data = {$urandom, $urandom};
      end
      @(negedge clk);
      if (rd_req) begin
        pend = 1;
        cnt  = lat_rand ? int'($urandom_range(1, 5)) : lat_fix;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_start(input logic [AL-1:0] b, output int e);
    start = 1'b1; base_addr = b;
    tick();
    e = cyc;
    start = 1'b0; base_addr = AL'($urandom);
  endtask

  task automatic do_release();
    release_s = 1'b1;
    tick();
    release_s = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!tile_ready && n < budget) begin tick(); n++; end
    chk("wait_ready_timeout", tile_ready, 1'b1);
    tick();
  endtask

  task automatic clear_logs();
    req_log.delete(); wr_log.delete(); done_log.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, tile_ready, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_req"}, rd_req, 0);
    chk({tag, "_addr"}, rd_addr, 0);
    chk({tag, "_wen"}, wen, 0);
    chk({tag, "_buf_in"}, buf_in, 0);
    chk({tag, "_buf_r"}, buf_r, 0);
    chk({tag, "_buf_c"}, buf_c, 0);
    chk({tag, "_r_en"}, r_en, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int e;
    reset = 1'b1; start = 1'b0; release_s = 1'b0; base_addr = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // Basic fill, latency 1.
    clear_logs();
    do_start(12'h010, e);
    wait_ready(200);
    chk("basic_nreq", req_log.size(), NCH);
    chk("basic_req0", req_log[0], 12'h010);
    chk("basic_req1", req_log[1], 12'h011);
    chk("basic_req2", req_log[2], 12'h012);
    chk("basic_req3", req_log[3], 12'h013);
    chk("basic_req7", req_log[7], 12'h017);
    chk("basic_wr0", wr_log[0], 0);
    chk("basic_wr1", wr_log[1], 4);
    chk("basic_wr2", wr_log[2], 100);
    chk("basic_wr3", wr_log[3], 104);
    chk("basic_wr7", wr_log[7], 304);
    chk("basic_ndone", done_log.size(), 1);
    chk("basic_done_lat", done_log[0] - e, 3 * NCH);
    repeat (3) tick();
    chk("basic_hold_ready", tile_ready, 1);
    do_release();
    tick();

    // Random latency with spurious valids.
    lat_rand = 1; spur_en = 1;
    for (int t = 0; t < 4; t++) begin
      clear_logs();
      do_start(AL'($urandom), e);
      wait_ready(600);
      chk("rand_nwr", wr_log.size(), NCH);
      chk("rand_nreq", req_log.size(), NCH);
      chk("rand_ndone", done_log.size(), 1);
      repeat ($urandom_range(0, 3)) tick();
      do_release();
      repeat ($urandom_range(0, 3)) tick();
    end
    lat_rand = 0; spur_en = 0;

    // Address wrap at the top of the line address space.
    lat_fix = 2;
    clear_logs();
    do_start(12'hFFE, e);
    wait_ready(300);
    chk("wrap_req0", req_log[0], 12'hFFE);
    chk("wrap_req1", req_log[1], 12'hFFF);
    chk("wrap_req2", req_log[2], 12'h000);
    chk("wrap_req3", req_log[3], 12'h001);
    do_release();
    tick();

    // start/release during WAIT are ignored.
    lat_fix = 3;
    clear_logs();
    do_start(12'h040, e);
    tick();
    start = 1'b1; release_s = 1'b1; base_addr = 12'h7AB;
    tick();
    start = 1'b0; release_s = 1'b0;
    wait_ready(300);
    chk("ign_nreq", req_log.size(), NCH);
    chk("ign_req0", req_log[0], 12'h040);
    chk("ign_req7", req_log[7], 12'h047);
    // start together with release in READY: back to idle, no new fill.
    start = 1'b1; release_s = 1'b1; base_addr = 12'h123;
    tick();
    start = 1'b0; release_s = 1'b0;
    repeat (6) tick();
    chk("ign_idle_busy", busy, 0);
    chk("ign_no_new_req", req_log.size(), NCH);

    // Reset while a request is outstanding.
    lat_fix = 5;
    clear_logs();
    do_start(12'h300, e);
    tick();
    reset = 1'b1;
    tick();
    chk_all_zero("midreset");
    reset = 1'b0;
    repeat (8) tick();
    chk("midreset_no_write", wr_log.size(), 0);
    lat_fix = 1;
    clear_logs();
    do_start(12'h200, e);
    wait_ready(200);
    chk("restart_req0", req_log[0], 12'h200);
    chk("restart_wr0", wr_log[0], 0);
    chk("restart_nwr", wr_log.size(), NCH);

    // Back-to-back tiles.
    clear_logs();
    do_release();
    do_start(12'h100, e);
    wait_ready(200);
    chk("b2b_req0", req_log[0], 12'h100);
    chk("b2b_ndone", done_log.size(), 1);
    do_release();
    do_start(12'h180, e);
    wait_ready(200);
    chk("b2b2_req8", req_log[NCH], 12'h180);
    chk("b2b2_ndone", done_log.size(), 2);
    do_release();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_buffer_loader.md
# input_buffer_loader

Sequences the fill of the input activation buffer from input SRAM. On `start` it fetches one full `INPUT_HEIGHT` x `INPUT_WIDTH` tile, one SRAM line at a time. Each line is written into the buffer at the correct row and column offset. When the tile is complete, the block gates the buffer's read enable on and holds the tile stable until the consuming PE array releases it. It sits between the top-level layer controller, the input SRAM read port and the input buffer's write/read controls.

## Interface
Parameters:
- `BIN_LEN`, 16, bits per activation word
- `INPUT_HEIGHT`, 4, buffer rows
- `INPUT_WIDTH`, 8, buffer columns; must be an integer multiple of `INPUT_SRAM_LEN`
- `INPUT_SRAM_LEN`, 4, words per SRAM line (words per buffer write)
- `ADDR_LEN`, 12, SRAM line address width

Ports:
- `clock`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `start`  in  1  begin a tile fill; sampled only in IDLE
- `base_addr`  in  ADDR_LEN  SRAM line address of tile row 0, chunk 0; captured with `start`
- `release`  in  1  consumer done with tile; sampled only in READY
- `busy`  out  1  high in every state except IDLE
- `tile_ready`  out  1  high in READY
- `done`  out  1  one-cycle pulse on READY entry
- `sram_rd_req`  out  1  one-cycle read request
- `sram_rd_addr`  out  ADDR_LEN  line address, valid with `sram_rd_req`
- `sram_rd_valid`  in  1  read data valid; any latency >= 1 cycle after request
- `sram_rd_data`  in  BIN_LEN*INPUT_SRAM_LEN  line data, word k at bits [k*BIN_LEN +: BIN_LEN]
- `buf_w_enable`  out  1  buffer write strobe
- `buf_in`  out  BIN_LEN*INPUT_SRAM_LEN  registered line data to buffer
- `buf_r`  out  clog2(INPUT_HEIGHT)  target row
- `buf_c`  out  clog2(INPUT_WIDTH)  target starting column
- `buf_r_enable`  out  1  equals `tile_ready`

## Operation
- States: IDLE, REQ, WAIT, WRITE, READY.
- IDLE -> REQ when `start` is high; capture `base_addr`; clear the row and chunk counters.
- REQ: assert `sram_rd_req` for one cycle with `sram_rd_addr` = captured base + row*CPR + chunk, where CPR = INPUT_WIDTH/INPUT_SRAM_LEN. The sum is truncated to ADDR_LEN, so it wraps modulo 2^ADDR_LEN. Next state is WAIT.
- WAIT: when `sram_rd_valid` is high, latch `sram_rd_data` into the `buf_in` register and go to WRITE. Stay in WAIT otherwise; there is no timeout.
- WRITE: assert `buf_w_enable` with `buf_r` = row and `buf_c` = chunk*INPUT_SRAM_LEN.
  - If this is the last chunk of the last row (row = INPUT_HEIGHT-1, chunk = CPR-1), go to READY.
  - Otherwise advance chunk. Chunk wraps to 0 after CPR-1, and row then increments. Return to REQ.
- READY: `tile_ready` = `buf_r_enable` = 1. `done` pulses on the entry cycle only. On `release` go to IDLE.
- Only one SRAM request is outstanding at any time.
- Ignored inputs:
  - `start` outside IDLE (no restart, no re-capture of `base_addr`)
  - `release` outside READY
  - `sram_rd_valid` outside WAIT
- Rows are filled top to bottom, and chunks left to right within a row.

## Timing
- Reset values: `busy`, `tile_ready`, `done`, `sram_rd_req`, `buf_w_enable` and `buf_r_enable` are 0. `sram_rd_addr`, `buf_in`, `buf_r` and `buf_c` are 0. State is IDLE and the counters are 0.
- `reset` asserted in any state, including mid-fill or in WAIT with a read outstanding, returns to IDLE on the next edge with all outputs at their reset values. A late `sram_rd_valid` arriving after reset is ignored.
- `start` sampled at edge t: REQ (request visible) in cycle t+1.
- Per chunk: 1 REQ + L WAIT + 1 WRITE cycles, where L >= 1 is the SRAM latency.
- With L = 1 a tile takes 3*INPUT_HEIGHT*CPR cycles from the first REQ to READY entry.
- `buf_w_enable`, `buf_in`, `buf_r` and `buf_c` are all registered and stable together for exactly the WRITE cycle.
- `release` and `start` high in the same READY cycle: go to IDLE. That `start` is not honoured; a new fill requires `start` in IDLE.
- `sram_rd_valid` in the same cycle as `sram_rd_req` (REQ state) is ignored.

## Test plan
Default parameters unless noted.
- **Basic fill:** H=2, W=4, L=2, `base_addr`=0x010, SRAM latency 1, `start` pulse.
  - Requests go to 0x010, 0x011, 0x012, 0x013.
  - Writes go to (r,c) = (0,0), (0,2), (1,0), (1,2) with matching data.
  - `done` pulses at cycle 13 after `start`; `tile_ready` stays high until `release`.
- **Variable latency:** random 1–5 cycle `sram_rd_valid` delay, plus spurious valids in REQ/WRITE/IDLE.
  - Exactly 8 writes (default params: 4 rows x 2 chunks).
  - Each write carries the data from the response to its own request; spurious valids cause no writes.
- **Address wrap:** ADDR_LEN=4, `base_addr`=0xE, H=2, W=4, L=2.
  - Request addresses are 0xE, 0xF, 0x0, 0x1.
- **Ignored controls:**
  - `start` during WAIT: `base_addr` is not re-captured and the fill completes normally.
  - `release` during a fill: no effect.
  - `start` and `release` together in READY: back to IDLE with no new requests.
- **Reset mid-operation:** `reset` in WAIT with a request outstanding.
  - Next cycle all outputs are 0.
  - A late `sram_rd_valid` produces no write.
  - A subsequent `start` restarts from row 0, chunk 0.
- **Back-to-back tiles:** `release`, then `start` with `base_addr`=0x100 in the IDLE cycle that follows.
  - The second tile's requests start at 0x100 and `done` pulses once per tile.
